// File: rtl/kraken_mmu_pkg.sv
// kraken_mmu shared definitions
// state encoding, defaults and address checks
package kraken_mmu_pkg;

  localparam logic [31:0] DEF_MEM_LIMIT = 32'h0001_0000;
  localparam int          DEF_LINES     = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_DRAIN = 2'd1,
    D_FILL   = 2'd2,
    I_FILL   = 2'd3
  } mmu_state_t;

  function automatic logic addr_bad(
    input logic [31:0] addr,
    input logic [31:0] limit
  );
    return (addr >= limit) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/kraken_mmu_line_cache.sv
// kraken_mmu direct-mapped word cache
// one lookup port, one allocate-or-update write port
module mmu_line_cache #(
  parameter int LINES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  output logic        hit,
  output logic [31:0] rd_data,
  input  logic        we,
  input  logic        alloc,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;

  logic [TW-1:0]    tags [LINES];
  logic [31:0]      data [LINES];
  logic [LINES-1:0] valid;

  logic [IW-1:0] idx;
  logic [IW-1:0] widx;
  logic [TW-1:0] tag;
  logic [TW-1:0] wtag;
  logic          wr_go;
  logic          unused;

  assign idx  = addr[IW+1:2];
  assign tag  = addr[31:IW+2];
  assign widx = waddr[IW+1:2];
  assign wtag = waddr[31:IW+2];

  assign unused = ^{addr[1:0], waddr[1:0]};

  assign hit     = valid[idx] && (tags[idx] == tag);
  assign rd_data = data[idx];

  // non-alloc writes only refresh a line already holding this word
  assign wr_go = we &&
    (alloc || (valid[widx] && (tags[widx] == wtag)));

  // valid bits: cleared on reset, set by any line write
  always_ff @(posedge clk) begin
    if (!rst_n)
      valid <= '0;
    else if (wr_go)
      valid[widx] <= 1'b1;
  end

  // tag and data storage, no reset needed behind valid
  always_ff @(posedge clk) begin
    if (wr_go) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  end

endmodule

// File: rtl/kraken_mmu.sv
// kraken_mmu top: split I/D word caches,
// one-deep posted write buffer, shared memory port
module kraken_mmu
  import kraken_mmu_pkg::*;
#(
  parameter logic [31:0] MEM_LIMIT = DEF_MEM_LIMIT,
  parameter int          LINES     = DEF_LINES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_rd,
  output logic [31:0] i_rd_data,
  output logic        i_miss,
  output logic        i_segfault,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wr_data,
  input  logic        d_rd,
  input  logic        d_wr,
  output logic [31:0] d_rd_data,
  output logic        d_miss,
  output logic        d_segfault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  mmu_state_t state;

  logic        i_bad;
  logic        d_bad;
  logic        i_ok;
  logic        d_rd_ok;
  logic        d_wr_ok;
  logic        i_hit;
  logic        d_hit;
  logic [31:0] i_line;
  logic [31:0] d_line;

  logic        buf_full;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;
  logic        wr_accept;

  logic        d_fill_ack;
  logic        i_fill_ack;
  logic        drain_ack;

  logic        d_we;
  logic [31:0] d_waddr;
  logic [31:0] d_wdata;
  logic        i_we;
  logic [31:0] i_waddr;
  logic [31:0] i_wdata;

  assign i_bad = addr_bad(i_addr, MEM_LIMIT);
  assign d_bad = addr_bad(d_addr, MEM_LIMIT);

  assign i_ok    = rst_n && i_rd && !i_bad;
  assign d_rd_ok = rst_n && d_rd && !d_wr && !d_bad;
  assign d_wr_ok = rst_n && d_wr && !d_rd && !d_bad;

  assign i_segfault = rst_n && i_rd && i_bad;
  assign d_segfault = rst_n && (d_rd || d_wr) &&
                      ((d_rd && d_wr) || d_bad);

  assign i_miss    = i_ok && !i_hit;
  assign i_rd_data = (i_ok && i_hit) ? i_line : '0;

  // a write that finds the buffer occupied is bounced
  assign d_miss    = (d_rd_ok && !d_hit) ||
                     (d_wr_ok && buf_full);
  assign d_rd_data = (d_rd_ok && d_hit) ? d_line : '0;

  assign wr_accept = d_wr_ok && !buf_full;

  assign d_fill_ack = (state == D_FILL) && mem_ack;
  assign i_fill_ack = (state == I_FILL) && mem_ack;
  assign drain_ack  = (state == WR_DRAIN) && mem_ack;

  assign mem_req = (state != IDLE);
  assign mem_we  = (state == WR_DRAIN);

  // fill data wins over a same-cycle posted write
  assign d_we    = d_fill_ack || wr_accept;
  assign d_waddr = d_fill_ack ? mem_addr : d_addr;
  assign d_wdata = d_fill_ack ? mem_rdata : d_wr_data;

  // I side only refreshes on writes, allocates on fills
  assign i_we    = i_fill_ack || wr_accept;
  assign i_waddr = i_fill_ack ? mem_addr : d_addr;
  assign i_wdata = i_fill_ack ? mem_rdata : d_wr_data;

  mmu_line_cache #(.LINES(LINES)) u_icache (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (i_addr),
    .hit     (i_hit),
    .rd_data (i_line),
    .we      (i_we),
    .alloc   (i_fill_ack),
    .waddr   (i_waddr),
    .wdata   (i_wdata)
  );

  mmu_line_cache #(.LINES(LINES)) u_dcache (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (d_addr),
    .hit     (d_hit),
    .rd_data (d_line),
    .we      (d_we),
    .alloc   (1'b1),
    .waddr   (d_waddr),
    .wdata   (d_wdata)
  );

  // posted write buffer: capture on accept, free on drain ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (drain_ack) begin
      buf_full <= 1'b0;
    end else if (wr_accept) begin
      buf_full <= 1'b1;
      buf_addr <= d_addr;
      buf_data <= d_wr_data;
    end
  end

  // memory sequencer: drain before D fill before I fill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (buf_full) begin
            state     <= WR_DRAIN;
            mem_addr  <= buf_addr;
            mem_wdata <= buf_data;
          end else if (d_rd_ok && !d_hit) begin
            state     <= D_FILL;
            mem_addr  <= d_addr;
            mem_wdata <= '0;
          end else if (i_ok && !i_hit) begin
            state     <= I_FILL;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
          end
        end
        WR_DRAIN, D_FILL, I_FILL: begin
          if (mem_ack)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
